// File: rtl/seq_player.sv
// Symbol recorder/player: captures channel edges into a small ring buffer
// and replays the stored codes as timed show/gap slots on a go edge.
module seq_player #(
  parameter  int NUM_CH   = 4,
  parameter  int DEPTH    = 16,
  parameter  int TICK_DIV = 25000000,
  localparam int CODE_W   = $clog2(NUM_CH+1),
  localparam int CNT_W    = $clog2(DEPTH)+1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic              go,
  input  logic              clear,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [NUM_CH-1:0]   r_ch;
  logic                r_go;
  logic [TICK_W-1:0]   r_tick;
  logic [PTR_W-1:0]    r_wp;
  logic [PTR_W-1:0]    r_rd;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_ovf;
  logic [CODE_W-1:0]   r_code;
  logic                r_valid;
  logic                r_busy;
  logic [CODE_W-1:0]   r_mem [DEPTH];

  logic [NUM_CH-1:0]   w_ch_rise;
  logic                w_go_rise;
  logic [CODE_W-1:0]   w_code;
  logic                w_tick_end;
  logic                w_last;
  logic                w_rec;
  logic                w_start;

  assign w_ch_rise  = ch_in & ~r_ch;
  assign w_go_rise  = go & ~r_go;
  assign w_tick_end = (r_tick == TICK_W'(TICK_DIV-1));
  assign w_last     = (r_idx == r_count - CNT_W'(1));
  assign w_rec      = (r_state == S_IDLE) && (|w_ch_rise) && !clear;
  assign w_start    = (r_state == S_IDLE) && w_go_rise &&
                      (r_count != '0) && !clear;

  // lowest edged channel wins; the rest are silently dropped
  always_comb begin
    w_code = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (w_ch_rise[i]) w_code = CODE_W'(i+1);
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_go_rise && r_count != '0) w_nxt = S_SHOW;
      S_SHOW: if (w_tick_end) w_nxt = S_GAP;
      S_GAP:  if (w_tick_end) w_nxt = w_last ? S_IDLE : S_SHOW;
      default: w_nxt = S_IDLE;
    endcase
    if (clear) w_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_go    <= 1'b0;
      r_tick  <= '0;
    end else begin
      r_state <= w_nxt;
      r_ch    <= ch_in;
      r_go    <= go;
      if (w_nxt != r_state || w_tick_end) r_tick <= '0;
      else                                r_tick <= r_tick + TICK_W'(1);
    end
  end

  // read pointer starts at the oldest entry: write pointer minus count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rd    <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_wp    <= '0;
      r_rd    <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_rec) begin
        if (r_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_wp    <= r_wp + PTR_W'(1);
          r_count <= r_count + CNT_W'(1);
          r_full  <= (r_count + CNT_W'(1) == CNT_W'(DEPTH));
        end
      end
      if (w_start) begin
        r_rd  <= r_wp - PTR_W'(r_count);
        r_idx <= '0;
      end else if (r_state == S_GAP && w_tick_end && !w_last) begin
        r_rd  <= r_rd + PTR_W'(1);
        r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_rec && !r_full) r_mem[r_wp] <= w_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (clear) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (r_state == S_SHOW);
      r_code  <= (r_state == S_SHOW) ? r_mem[r_rd] : '0;
      r_busy  <= (r_state != S_IDLE);
    end
  end

  assign out_code  = r_code;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign count     = r_count;
  assign full      = r_full;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: directed scenarios plus random stimulus,
// checked every cycle against a slot-timeline model of playback.
module tb_seq_player;

  localparam int NCH  = 4;
  localparam int DEP  = 4;
  localparam int TD   = 4;
  localparam int SLOT = 2*TD;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] ch_in = '0;
  logic           go    = 1'b0;
  logic           clear = 1'b0;
  logic [2:0]     out_code;
  logic           out_valid;
  logic           busy;
  logic [2:0]     count;
  logic           full;
  logic           overflow;

  seq_player #(.NUM_CH(NCH), .DEPTH(DEP), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .ch_in(ch_in), .go(go),
    .clear(clear), .out_code(out_code), .out_valid(out_valid),
    .busy(busy), .count(count), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: stored codes as a queue, playback as a timeline of slots
  int       q[$];
  int       seq[$];
  int       m_ovf  = 0;
  bit       m_play = 0;
  int       m_t    = 0;
  int       m_n    = 0;
  logic [NCH-1:0] m_pch = '0;
  logic     m_pgo  = 1'b0;
  int       e_code = 0;
  int       e_valid = 0;
  int       e_busy = 0;
  logic [NCH-1:0] rise;
  bit       gor, idle;
  int       j;

  function automatic int lowest(logic [NCH-1:0] r);
    for (int i = 0; i < NCH; i++) if (r[i]) return i+1;
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf = 0; m_play = 0; m_t = 0; m_n = 0;
      m_pch = '0; m_pgo = 1'b0;
      e_code = 0; e_valid = 0; e_busy = 0;
    end else begin
      rise  = ch_in & ~m_pch;
      gor   = go & ~m_pgo;
      m_pch = ch_in;
      m_pgo = go;
      if (clear) begin
        q.delete();
        m_ovf = 0; m_play = 0; m_t = 0;
        e_code = 0; e_valid = 0; e_busy = 0;
      end else begin
        idle = !m_play || (m_t >= SLOT*m_n);
        if (m_play) m_t++;
        if (idle && gor && q.size() > 0) begin
          m_play = 1; m_t = 0; m_n = q.size(); seq = q;
        end
        if (idle && rise != '0) begin
          if (q.size() == DEP) m_ovf = 1;
          else q.push_back(lowest(rise));
        end
        if (m_play && m_t >= 1 && m_t <= SLOT*m_n) begin
          j = m_t - 1;
          e_busy  = 1;
          e_valid = ((j % SLOT) < TD) ? 1 : 0;
          e_code  = e_valid ? seq[j / SLOT] : 0;
        end else begin
          e_code = 0; e_valid = 0; e_busy = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("out_code",  int'(out_code),  e_code);
      chk("out_valid", int'(out_valid), e_valid);
      chk("busy",      int'(busy),      e_busy);
      chk("count",     int'(count),     q.size());
      chk("full",      int'(full),      (q.size() == DEP) ? 1 : 0);
      chk("overflow",  int'(overflow),  m_ovf);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse(int c);
    ch_in[c] = 1'b1; tick();
    ch_in    = '0;   tick();
  endtask

  int cap[$];
  int bcnt, vcnt;

  task automatic play(int cyc);
    logic pv;
    cap.delete(); bcnt = 0; vcnt = 0; pv = 1'b0;
    go = 1'b1; tick();
    go = 1'b0;
    repeat (cyc) begin
      tick();
      if (busy) bcnt++;
      if (out_valid) vcnt++;
      if (out_valid && !pv) cap.push_back(int'(out_code));
      pv = out_valid;
    end
  endtask

  task automatic chk_seq(string nm, int e0, int e1, int e2, int e3, int n);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    chk({nm, "_len"}, cap.size(), n);
    for (int i = 0; i < n; i++)
      chk(nm, (i < cap.size()) ? cap[i] : -1, ex[i]);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
    clear = 1'b0; tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_code",  int'(out_code),  0);
    chk("rst_busy",  int'(busy),      0);
    chk("rst_count", int'(count),     0);
    reset = 1'b1;
    tick();
    chk_en = 1;

    // four channels in turn, then a full playback
    for (int c = 0; c < 4; c++) pulse(c);
    chk("fill_count", int'(count), 4);
    chk("fill_full",  int'(full),  1);
    chk("model_cnt",  q.size(),    4);
    play(40);
    chk_seq("play1234", 1, 2, 3, 4, 4);
    chk("busy_cycles",  bcnt, 32);
    chk("valid_cycles", vcnt, 16);

    // overflow while full, then clear
    pulse(1);
    chk("ovf_count", int'(count),    4);
    chk("ovf_flag",  int'(overflow), 1);
    do_clear();
    chk("clr_count", int'(count),    0);
    chk("clr_ovf",   int'(overflow), 0);
    chk("clr_full",  int'(full),     0);

    // clear wins over a same-cycle record
    ch_in = 4'b0100; clear = 1'b1; tick();
    ch_in = '0; clear = 1'b0; tick();
    chk("clr_prio", int'(count), 0);

    // simultaneous edges keep only the lowest channel
    ch_in = 4'b1010; tick();
    ch_in = '0; tick();
    chk("multi_count", int'(count), 1);
    play(16);
    chk_seq("multi", 2, 0, 0, 0, 1);

    // edges during playback are ignored; replay is identical
    do_clear();
    pulse(2); pulse(0);
    go = 1'b1; tick(); go = 1'b0; tick();
    pulse(0);
    chk("busy_ign", int'(count), 2);
    repeat (20) tick();
    play(24);
    chk_seq("replay", 3, 1, 0, 0, 2);

    // async reset in the second gap aborts playback
    do_clear();
    pulse(0); pulse(1); pulse(2);
    go = 1'b1; tick(); go = 1'b0; tick();
    repeat (12) tick();
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b0; #1;
    chk("arst_code",  int'(out_code),  0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy",  int'(busy),      0);
    chk("arst_count", int'(count),     0);
    tick();
    reset = 1'b1; tick();
    play(6);
    chk("go_empty_busy", bcnt, 0);

    // store, clear, store again: write order preserved
    for (int c = 0; c < 4; c++) pulse(c);
    do_clear();
    pulse(3); pulse(2); pulse(1);
    play(30);
    chk_seq("after_clr", 4, 3, 2, 0, 3);

    // random traffic; go and channel changes never share a cycle
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      clear = ($urandom_range(0, 59) == 0);
      if (r < 6) go = ~go;
      else if (r < 40) ch_in = NCH'($urandom);
      tick();
    end
    clear = 1'b0; go = 1'b0; ch_in = '0;
    repeat (40) tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels, legal range 2..8.
REQ-002 SHALL have parameter DEPTH, default 16, symbol buffer depth, power of two, at least 2.
REQ-003 SHALL have parameter TICK_DIV, default 25000000, clock cycles per display slot, at least 2.
REQ-004 SHALL derive CODE_W = clog2(NUM_CH+1) and CNT_W = clog2(DEPTH)+1.
REQ-005 SHALL have port clock, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ch_in, input, NUM_CH, one level per input channel (toggle, push, mic, mouse, ...).
REQ-008 SHALL have port go, input, 1, level; its rising edge starts playback.
REQ-009 SHALL have port clear, input, 1, synchronous buffer clear, active high.
REQ-010 SHALL have port out_code, output, CODE_W, symbol being shown; 0 means none.
REQ-011 SHALL have port out_valid, output, 1, high while a symbol slot is shown.
REQ-012 SHALL have port busy, output, 1, high while playback runs.
REQ-013 SHALL have port count, output, CNT_W, number of stored symbols.
REQ-014 SHALL have port full, output, 1, high when count equals DEPTH.
REQ-015 SHALL have port overflow, output, 1, sticky flag for a lost symbol.

Function
REQ-016 SHALL register ch_in and go once each cycle and detect rising edges against the previous registered value; the edge registers track inputs in every state.
REQ-017 SHALL record a symbol only in IDLE, on a cycle with at least one channel rising edge; the symbol code is lowest edged channel index + 1.
REQ-018 SHALL drop the remaining edged channels when several channels rise in the same cycle, without setting overflow.
REQ-019 SHALL write the symbol at the write pointer and increment count the next cycle; pointers wrap modulo DEPTH.
REQ-020 SHALL drop a symbol that arrives while full, set overflow, and leave count unchanged.
REQ-021 SHALL ignore channel edges while busy; nothing is recorded and overflow does not change.
REQ-022 SHALL use a free tick counter 0..TICK_DIV-1 that reloads to 0 on every state entry; one slot is TICK_DIV cycles.
REQ-023 SHALL use the FSM states IDLE, SHOW and GAP.
REQ-024 IDLE: on a go rising edge with count>0, SHALL move to SHOW with the read index at the oldest symbol; a go edge with count=0 SHALL be ignored.
REQ-025 SHOW: SHALL drive out_code = symbol[read index] and out_valid=1 for TICK_DIV cycles, then move to GAP.
REQ-026 GAP: SHALL drive out_code=0 and out_valid=0 for TICK_DIV cycles, then increment the read index and return to SHOW, or go to IDLE after the last stored symbol.
REQ-027 SHALL make playback non-destructive: the buffer and count are unchanged and a later go replays the same sequence.
REQ-028 SHALL hold busy=1 in SHOW and GAP and busy=0 in IDLE.
REQ-029 SHALL ignore go edges while busy.
REQ-030 SHALL act on clear in any state on the next edge: count=0, pointers=0, overflow=0, FSM to IDLE, out_code=0, out_valid=0.
REQ-031 SHALL give clear priority over a same-cycle symbol record and over a same-cycle go.
REQ-032 SHALL register all outputs; out_code and out_valid change one cycle after the state transition.

Reset
REQ-033 On reset low, SHALL immediately and asynchronously set: FSM=IDLE, pointers=0, count=0, overflow=0, out_code=0, out_valid=0, busy=0, tick counter=0, edge registers=0.
REQ-034 SHALL treat reset asserted mid-playback as an abort: buffer contents are lost and no partial slot persists.
REQ-035 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Verification (NUM_CH=4, DEPTH=4, TICK_DIV=4)
REQ-036 Pulse ch 0, 1, 2, 3 in turn, then go -> count=4, full=1; out_code shows 1,2,3,4, each out_valid for 4 cycles with a 4-cycle 0 gap between; busy low after 32 cycles.
REQ-037 With full=1, pulse ch 1 -> count stays 4, overflow=1; then clear -> count=0, overflow=0, full=0.
REQ-038 Raise ch 1 and ch 3 in the same cycle -> one symbol stored, code 2; count=1.
REQ-039 Store 2 symbols, go, pulse ch 0 during SHOW -> count stays 2; a second go after IDLE replays the same two codes.
REQ-040 Store 3 symbols, go, assert reset during the second GAP -> all outputs 0 at once; a following go with count=0 leaves busy=0.
REQ-041 Store 4, clear, store 3, play -> the codes play in write order across pointer wrap-around.
